// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and instruction constants for the sequencer
package seq_pkg;
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [31:0] EBREAK = 32'h00100073;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational field extraction and addi/bne/ebreak classification
module instr_decode
  import seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] imm,
  output logic [12:0] boff,
  output logic        is_addi,
  output logic        is_bne,
  output logic        is_ebreak,
  output logic        is_illegal
);
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd = instr[11:7];
  assign imm = instr[31:20];
  assign boff = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign is_addi = instr[6:0] == OP_IMM && instr[14:12] == F3_ADDI;
  assign is_bne = instr[6:0] == OP_BRANCH && instr[14:12] == F3_BNE;
  assign is_ebreak = instr == EBREAK;
  assign is_illegal = !(is_addi || is_bne || is_ebreak);
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: pc, instruction fetch and addi/bne/ebreak control sequencing
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_WIDTH = 16,
  parameter int ADD_WIDTH = 5,
  parameter int IMM_WIDTH = 12,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic [INSTR_WIDTH-1:0] imemRdata,
  input  logic                   imemValid,
  input  logic                   EQ,
  output logic [ADD_WIDTH-1:0]   rs1,
  output logic [ADD_WIDTH-1:0]   rs2,
  output logic [ADD_WIDTH-1:0]   rd,
  output logic                   RegWrite,
  output logic [IMM_WIDTH-1:0]   ImmOp,
  output logic                   ALUsrc,
  output logic                   ALUctrl,
  output logic                   halted,
  output logic                   fault,
  output logic [15:0]            instrRetired
);
  state_t state, n_state;
  logic [PC_WIDTH-1:0] pc, n_pc, tgt;
  logic [INSTR_WIDTH-1:0] instr;
  logic go, n_fault, retire, ex, acc;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic [11:0] d_imm;
  logic [12:0] boff;
  logic is_addi, is_bne, is_ebreak, is_illegal;
  logic [ADD_WIDTH-1:0] h_rs1, h_rs2, h_rd;
  logic [IMM_WIDTH-1:0] h_imm;
  logic h_src, h_ctrl;
  instr_decode u_dec (
    .instr(instr),
    .rs1(d_rs1),
    .rs2(d_rs2),
    .rd(d_rd),
    .imm(d_imm),
    .boff(boff),
    .is_addi(is_addi),
    .is_bne(is_bne),
    .is_ebreak(is_ebreak),
    .is_illegal(is_illegal)
  );
  assign ex = state == EXEC;
  assign imemReq = state == FETCH && go;
  assign acc = imemReq && imemValid;
  assign imemAddr = pc;
  assign halted = state == HALT;
  assign tgt = pc + PC_WIDTH'($signed(boff));
  assign rs1 = ex && (is_addi || is_bne) ? ADD_WIDTH'(d_rs1) : h_rs1;
  assign rs2 = ex && is_bne ? ADD_WIDTH'(d_rs2) : h_rs2;
  assign rd = ex && is_addi ? ADD_WIDTH'(d_rd) : h_rd;
  assign ImmOp = ex && is_addi ? IMM_WIDTH'(d_imm) : h_imm;
  assign ALUsrc = ex && is_addi ? 1'b1 : ex && is_bne ? 1'b0 : h_src;
  assign ALUctrl = ex && is_addi ? 1'b0 : ex && is_bne ? 1'b1 : h_ctrl;
  assign RegWrite = ex && is_addi && d_rd != 5'd0;
  always_comb begin
    n_state = state;
    n_pc = pc;
    n_fault = fault;
    retire = 1'b0;
    if (state == FETCH && acc) n_state = EXEC;
    else if (ex) begin
      n_state = FETCH;
      if (is_ebreak) begin
        n_state = HALT;
        retire = 1'b1;
      end else if (is_illegal || (is_bne && !EQ && tgt[1])) begin
        n_state = HALT;
        n_fault = 1'b1;
      end else begin
        retire = 1'b1;
        n_pc = is_bne && !EQ ? tgt : pc + PC_WIDTH'(4);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= '0;
      instr <= '0;
      go <= 1'b0;
      fault <= 1'b0;
      instrRetired <= '0;
      h_rs1 <= '0;
      h_rs2 <= '0;
      h_rd <= '0;
      h_imm <= '0;
      h_src <= 1'b0;
      h_ctrl <= 1'b0;
    end else begin
      state <= n_state;
      pc <= n_pc;
      instr <= acc ? imemRdata : instr;
      go <= 1'b1;
      fault <= n_fault;
      instrRetired <= instrRetired + 16'(retire && instrRetired != 16'hFFFF);
      h_rs1 <= rs1;
      h_rs2 <= rs2;
      h_rd <= rd;
      h_imm <= ImmOp;
      h_src <= ALUsrc;
      h_ctrl <= ALUctrl;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench with directed fetch/exec vectors
module tb_instr_sequencer;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic        src;
    logic        ctrl;
    logic        rw;
  } exec_t;
  logic clk, rst_n, imemReq, imemValid, EQ, RegWrite, ALUsrc, ALUctrl, halted, fault;
  logic [15:0] imemAddr, instrRetired;
  logic [31:0] imemRdata;
  logic [4:0] rs1, rs2, rd;
  logic [11:0] ImmOp;
  logic was_acc;
  int checks = 0;
  int errors = 0;
  logic [15:0] fq[$];
  exec_t xq[$];
  instr_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .imemReq(imemReq),
    .imemAddr(imemAddr),
    .imemRdata(imemRdata),
    .imemValid(imemValid),
    .EQ(EQ),
    .rs1(rs1),
    .rs2(rs2),
    .rd(rd),
    .RegWrite(RegWrite),
    .ImmOp(ImmOp),
    .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl),
    .halted(halted),
    .fault(fault),
    .instrRetired(instrRetired)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) was_acc <= 1'b0;
    else begin
      if (was_acc) begin
        if (xq.size() == 0) chk("exec_unexpected", 1, 0);
        else begin
          chk("exec_rs1", rs1, xq[0].rs1);
          chk("exec_rs2", rs2, xq[0].rs2);
          chk("exec_rd", rd, xq[0].rd);
          chk("exec_imm", ImmOp, xq[0].imm);
          chk("exec_alusrc", ALUsrc, xq[0].src);
          chk("exec_aluctrl", ALUctrl, xq[0].ctrl);
          chk("exec_regwrite", RegWrite, xq[0].rw);
          void'(xq.pop_front());
        end
      end
      if (imemReq && imemValid) begin
        if (fq.size() == 0) chk("fetch_unexpected", 1, 0);
        else begin
          chk("fetch_addr", imemAddr, fq[0]);
          void'(fq.pop_front());
        end
      end
      was_acc <= imemReq && imemValid;
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    imemValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", imemReq, 0);
    chk("rst_rw", RegWrite, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retired", instrRetired, 0);
    chk("rst_addr", imemAddr, 0);
    #2 rst_n = 1'b1;
    #1 chk("release_req", imemReq, 0);
    @(posedge clk);
    #1;
    chk("first_req", imemReq, 1);
    chk("first_addr", imemAddr, 0);
  endtask
  task automatic fetch(input logic [31:0] data, input logic [15:0] addr, input logic eq, input exec_t e);
    int n = 0;
    while (!imemReq && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fetch_req", imemReq, 1);
    fq.push_back(addr);
    xq.push_back(e);
    imemRdata = data;
    imemValid = 1'b1;
    EQ = eq;
    @(posedge clk);
    #1 imemValid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    imemValid = 1'b0;
    imemRdata = '0;
    EQ = 1'b0;
    do_reset();
    fetch(32'h00500513, 16'h0000, 1'b0, '{5'd0, 5'd0, 5'd10, 12'd5, 1'b1, 1'b0, 1'b1});
    chk("addi_retired", instrRetired, 1);
    chk("addi_next_addr", imemAddr, 16'h0004);
    chk("addi_rw_pulse", RegWrite, 0);
    fetch(32'h00100593, 16'h0004, 1'b0, '{5'd0, 5'd0, 5'd11, 12'd1, 1'b1, 1'b0, 1'b1});
    fetch(32'hFEB51EE3, 16'h0008, 1'b0, '{5'd10, 5'd11, 5'd11, 12'd1, 1'b0, 1'b1, 1'b0});
    chk("bne_taken_addr", imemAddr, 16'h0004);
    fetch(32'h00100593, 16'h0004, 1'b0, '{5'd0, 5'd11, 5'd11, 12'd1, 1'b1, 1'b0, 1'b1});
    fetch(32'hFEB51EE3, 16'h0008, 1'b1, '{5'd10, 5'd11, 5'd11, 12'd1, 1'b0, 1'b1, 1'b0});
    chk("bne_fall_addr", imemAddr, 16'h000C);
    chk("bne_retired", instrRetired, 5);
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", imemReq, 1);
      chk("stall_addr", imemAddr, 16'h000C);
      chk("stall_rw", RegWrite, 0);
      chk("stall_retired", instrRetired, 5);
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    fetch(32'h00500513, 16'h000C, 1'b0, '{5'd0, 5'd11, 5'd10, 12'd5, 1'b1, 1'b0, 1'b1});
    chk("stall_done_retired", instrRetired, 6);
    fetch(32'h00000013, 16'h0010, 1'b0, '{5'd0, 5'd11, 5'd0, 12'd0, 1'b1, 1'b0, 1'b0});
    chk("nop_retired", instrRetired, 7);
    chk("nop_addr", imemAddr, 16'h0014);
    fetch(32'h00000033, 16'h0014, 1'b0, '{5'd0, 5'd11, 5'd0, 12'd0, 1'b1, 1'b0, 1'b0});
    chk("ill_halted", halted, 1);
    chk("ill_fault", fault, 1);
    chk("ill_req", imemReq, 0);
    chk("ill_retired", instrRetired, 7);
    imemRdata = 32'h00500513;
    imemValid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    imemValid = 1'b0;
    chk("halt_stuck", halted, 1);
    chk("halt_req", imemReq, 0);
    chk("halt_addr", imemAddr, 16'h0014);
    chk("halt_rw", RegWrite, 0);
    chk("halt_retired", instrRetired, 7);
    do_reset();
    fq.push_back(16'h0000);
    xq.push_back('{5'd0, 5'd0, 5'd10, 12'd5, 1'b1, 1'b0, 1'b1});
    imemRdata = 32'h00500513;
    imemValid = 1'b1;
    @(posedge clk);
    #1 imemValid = 1'b0;
    chk("midexec_rw_high", RegWrite, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midexec_rw_drop", RegWrite, 0);
    chk("midexec_req_drop", imemReq, 0);
    chk("midexec_addr", imemAddr, 0);
    chk("midexec_retired", instrRetired, 0);
    chk("midexec_rd", rd, 0);
    do_reset();
    fetch(32'h00100073, 16'h0000, 1'b0, '{5'd0, 5'd0, 5'd0, 12'd0, 1'b0, 1'b0, 1'b0});
    chk("ebreak_halted", halted, 1);
    chk("ebreak_fault", fault, 0);
    chk("ebreak_retired", instrRetired, 1);
    chk("ebreak_req", imemReq, 0);
    do_reset();
    fetch(32'h00001163, 16'h0000, 1'b0, '{5'd0, 5'd0, 5'd0, 12'd0, 1'b0, 1'b1, 1'b0});
    chk("misalign_halted", halted, 1);
    chk("misalign_fault", fault, 1);
    chk("misalign_addr", imemAddr, 0);
    chk("misalign_retired", instrRetired, 0);
    chk("fetch_queue_drained", fq.size(), 0);
    chk("exec_queue_drained", xq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
